// File: rtl/score_digit_renderer.sv
// Four-digit score renderer: binary -> BCD (double dabble), per-digit glyph
// ROM addressing and a 2-stage pixel merge. Optional: LEADING_ZERO_BLANK_EN.
// Ports: Clk, Reset_n (sync, active-low), score_in/score_load, DrawX/DrawY,
// rom_addr0..3 / rom_data0..3, busy, digits_out, pixel_on, pixel_color.
module score_digit_renderer #(
  parameter int X0         = 480,
  parameter int Y0         = 16,
  parameter int DIGIT_W    = 10,
  parameter int DIGIT_H    = 16,
  parameter int DIGIT_BASE = 580
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [13:0] score_in,
  input  logic        score_load,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [11:0] rom_addr0,
  output logic [11:0] rom_addr1,
  output logic [11:0] rom_addr2,
  output logic [11:0] rom_addr3,
  input  logic [2:0]  rom_data0,
  input  logic [2:0]  rom_data1,
  input  logic [2:0]  rom_data2,
  input  logic [2:0]  rom_data3,
  output logic        busy,
  output logic [15:0] digits_out,
  output logic        pixel_on,
  output logic [2:0]  pixel_color
);

  localparam logic [9:0]  XL = 10'(X0);
  localparam logic [9:0]  XH = 10'(X0 + 4*DIGIT_W);
  localparam logic [9:0]  YL = 10'(Y0);
  localparam logic [9:0]  YH = 10'(Y0 + DIGIT_H);
  localparam logic [9:0]  W1 = 10'(DIGIT_W);
  localparam logic [9:0]  W2 = 10'(2*DIGIT_W);
  localparam logic [9:0]  W3 = 10'(3*DIGIT_W);
  localparam logic [11:0] WA = 12'(DIGIT_W);
  localparam logic [11:0] GA = 12'(DIGIT_W*DIGIT_H);
  localparam logic [11:0] BA = 12'(DIGIT_BASE);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d, bcd_n;
  logic [3:0]  cnt_q, cnt_d;
  logic        pv_q, pv_d;
  logic [13:0] pend_q, pend_d;
  logic [15:0] dig_q, dig_d;
  logic [13:0] clamped;

  assign clamped = (score_in > 14'd9999) ? 14'd9999 : score_in;

  // One double-dabble iteration: add-3 on nibbles >= 5, then shift in MSB.
  always_comb begin
    logic [15:0] t;
    t = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        t[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bcd_n = {t[14:0], bin_q[13]};
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    pv_d    = pv_q;
    pend_d  = pend_q;
    dig_d   = dig_q;
    unique case (state_q)
      IDLE: begin
        if (score_load) begin
          state_d = CONV;
          bin_d   = clamped;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      CONV: begin
        bin_d = {bin_q[12:0], 1'b0};
        bcd_d = bcd_n;
        cnt_d = cnt_q + 4'd1;
        if (score_load) begin
          pv_d   = 1'b1;
          pend_d = clamped;
        end
        if (cnt_q == 4'd13) begin
          dig_d = bcd_n;
          // A load on this very cycle is newer than the stored pending one.
          if (score_load || pv_q) begin
            bin_d = score_load ? clamped : pend_q;
            bcd_d = '0;
            cnt_d = '0;
            pv_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      pend_q  <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pend_q  <= pend_d;
      dig_q   <= dig_d;
    end
  end

  assign busy       = (state_q == CONV);
  assign digits_out = dig_q;

  logic        in_field;
  logic [9:0]  dx, row, col, off;
  logic [1:0]  sel;
  logic [3:0]  dsel;
  logic [3:0]  blank;
  logic [11:0] gaddr;
  logic [11:0] addr [4];

`ifdef LEADING_ZERO_BLANK_EN
  // Port 0 is thousands; a digit blanks only if it and all above are zero.
  assign blank[0] = (dig_q[15:12] == 4'd0);
  assign blank[1] = blank[0] && (dig_q[11:8] == 4'd0);
  assign blank[2] = blank[1] && (dig_q[7:4] == 4'd0);
  assign blank[3] = 1'b0;
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    in_field = (DrawX >= XL) && (DrawX < XH) &&
               (DrawY >= YL) && (DrawY < YH);
    dx  = DrawX - XL;
    row = DrawY - YL;
    sel  = 2'd3;
    off  = W3;
    dsel = dig_q[3:0];
    unique case (1'b1)
      (dx < W1): begin sel = 2'd0; off = '0; dsel = dig_q[15:12]; end
      (dx >= W1 && dx < W2): begin
        sel = 2'd1; off = W1; dsel = dig_q[11:8];
      end
      (dx >= W2 && dx < W3): begin
        sel = 2'd2; off = W2; dsel = dig_q[7:4];
      end
      default: ;
    endcase
    col   = dx - off;
    gaddr = BA + {8'b0, dsel} * GA + {2'b0, row} * WA + {2'b0, col};
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      if (in_field && sel == 2'(i) && !blank[i])
        addr[i] = gaddr;
    end
  end

  assign rom_addr0 = addr[0];
  assign rom_addr1 = addr[1];
  assign rom_addr2 = addr[2];
  assign rom_addr3 = addr[3];

  logic       in_field_d, blank_d;
  logic [1:0] sel_d;
  logic [2:0] rd_sel, color_n;

  always_comb begin
    rd_sel = rom_data3;
    unique case (sel_d)
      2'd0: rd_sel = rom_data0;
      2'd1: rd_sel = rom_data1;
      2'd2: rd_sel = rom_data2;
      2'd3: rd_sel = rom_data3;
    endcase
    color_n = (in_field_d && !blank_d) ? rd_sel : 3'd0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      in_field_d  <= 1'b0;
      blank_d     <= 1'b0;
      sel_d       <= '0;
      pixel_color <= '0;
      pixel_on    <= 1'b0;
    end else begin
      in_field_d  <= in_field;
      blank_d     <= blank[sel];
      sel_d       <= sel;
      pixel_color <= color_n;
      pixel_on    <= (color_n != 3'd0);
    end
  end

endmodule

// File: tb/tb_score_digit_renderer.sv
// Self-checking bench for score_digit_renderer: conversion timing, clamping,
// pending loads, reset abort, glyph addressing and pixel pipeline.
module tb_score_digit_renderer;

  localparam int X0 = 480;
  localparam int Y0 = 16;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [13:0] score_in;
  logic        score_load;
  logic [9:0]  DrawX, DrawY;
  logic [11:0] rom_addr0, rom_addr1, rom_addr2, rom_addr3;
  logic [2:0]  rom_data0, rom_data1, rom_data2, rom_data3;
  logic        busy;
  logic [15:0] digits_out;
  logic        pixel_on;
  logic [2:0]  pixel_color;

  int checks = 0;
  int errors = 0;
  int shown  = 0;
  int pq[$];
  int p10[4] = '{1, 10, 100, 1000};

  score_digit_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .score_in(score_in), .score_load(score_load),
    .DrawX(DrawX), .DrawY(DrawY),
    .rom_addr0(rom_addr0), .rom_addr1(rom_addr1),
    .rom_addr2(rom_addr2), .rom_addr3(rom_addr3),
    .rom_data0(rom_data0), .rom_data1(rom_data1),
    .rom_data2(rom_data2), .rom_data3(rom_data3),
    .busy(busy), .digits_out(digits_out),
    .pixel_on(pixel_on), .pixel_color(pixel_color)
  );

  always #5 Clk = ~Clk;

  function automatic int romf(input int a);
    return (a * 5 + a / 7) % 8;
  endfunction

  always @(posedge Clk) begin
    rom_data0 <= 3'(romf(int'(rom_addr0)));
    rom_data1 <= 3'(romf(int'(rom_addr1)));
    rom_data2 <= 3'(romf(int'(rom_addr2)));
    rom_data3 <= 3'(romf(int'(rom_addr3)));
  end

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic bit blanked(input int port);
`ifdef LEADING_ZERO_BLANK_EN
    return port < 3 && shown < p10[3 - port];
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_addr(input int port, input int x, input int y);
    int i, d;
    if (x < X0 || x >= X0 + 40 || y < Y0 || y >= Y0 + 16) return 0;
    i = (x - X0) / 10;
    if (i != port || blanked(port)) return 0;
    d = (shown / p10[3 - port]) % 10;
    return 580 + d * 160 + (y - Y0) * 10 + (x - X0 - i * 10);
  endfunction

  function automatic int exp_pix(input int x, input int y);
    int i;
    if (x < X0 || x >= X0 + 40 || y < Y0 || y >= Y0 + 16) return 0;
    i = (x - X0) / 10;
    if (blanked(i)) return 0;
    return romf(exp_addr(i, x, y));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_pos(input int x, input int y, input string tag);
    @(negedge Clk);
    if (pq.size() == 2) begin
      check({tag, "_color"}, 32'(pixel_color), 32'(pq[0]));
      check({tag, "_on"}, 32'(pixel_on), 32'(pq[0] != 0));
      void'(pq.pop_front());
    end
    DrawX = 10'(x);
    DrawY = 10'(y);
    pq.push_back(exp_pix(x, y));
    #1;
    check({tag, "_a0"}, 32'(rom_addr0), 32'(exp_addr(0, x, y)));
    check({tag, "_a1"}, 32'(rom_addr1), 32'(exp_addr(1, x, y)));
    check({tag, "_a2"}, 32'(rom_addr2), 32'(exp_addr(2, x, y)));
    check({tag, "_a3"}, 32'(rom_addr3), 32'(exp_addr(3, x, y)));
  endtask

  task automatic scan(input int n, input string tag);
    pq.delete();
    for (int k = 0; k < n; k++)
      step_pos($urandom_range(X0 + 45, X0 - 5),
               $urandom_range(Y0 + 19, Y0 - 3), tag);
  endtask

  task automatic load_and_wait(input int v, input string tag);
    int n;
    @(negedge Clk);
    score_in = 14'(v);
    score_load = 1'b1;
    @(negedge Clk);
    score_load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      check({tag, "_hold"}, 32'(digits_out), 32'(to_bcd(shown)));
      n++;
      @(negedge Clk);
    end
    shown = (v > 9999) ? 9999 : v;
    check({tag, "_busy"}, 32'(n), 32'd14);
    check({tag, "_val"}, 32'(digits_out), 32'(to_bcd(shown)));
  endtask

  // Load a, then b at busy cycle nb, then optionally c at busy cycle nc.
  task automatic chain(input int a, input int b, input int nb,
                       input int c, input int nc, input string tag);
    int n;
    logic [15:0] prev;
    logic [15:0] seen[$];
    @(negedge Clk);
    score_in = 14'(a);
    score_load = 1'b1;
    @(negedge Clk);
    score_load = 1'b0;
    prev = digits_out;
    n = 0;
    while (busy === 1'b1 && n < 80) begin
      if (digits_out !== prev) begin
        seen.push_back(digits_out);
        prev = digits_out;
      end
      score_load = 1'b0;
      if (n == nb) begin score_in = 14'(b); score_load = 1'b1; end
      if (n == nc) begin score_in = 14'(c); score_load = 1'b1; end
      n++;
      @(negedge Clk);
    end
    score_load = 1'b0;
    if (digits_out !== prev) seen.push_back(digits_out);
    shown = (nc >= 0) ? c : b;
    check({tag, "_busy"}, 32'(n), 32'd28);
    check({tag, "_ncommit"}, 32'(seen.size()), 32'd2);
    if (seen.size() == 2) begin
      check({tag, "_first"}, 32'(seen[0]), 32'(to_bcd(a)));
      check({tag, "_last"}, 32'(seen[1]), 32'(to_bcd(shown)));
    end
  endtask

  initial begin
    int v;
    Reset_n = 1'b0;
    score_in = '0;
    score_load = 1'b0;
    DrawX = '0;
    DrawY = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_digits", 32'(digits_out), 32'd0);
    check("rst_on", 32'(pixel_on), 32'd0);
    check("rst_color", 32'(pixel_color), 32'd0);
    Reset_n = 1'b1;

    load_and_wait(1234, "c1234");
    pq.delete();
    step_pos(X0 + 25, Y0 + 3, "dir_in");
    check("dir_addr2", 32'(rom_addr2), 32'd1095);
    step_pos(X0 - 1, Y0 + 3, "dir_out");
    step_pos(X0 + 39, Y0 + 15, "dir_corner");
    step_pos(X0 + 40, Y0 + 15, "dir_right");
    step_pos(X0, Y0 + 16, "dir_below");
    step_pos(X0, Y0, "dir_origin");
    step_pos(X0, Y0, "dir_flush");
    step_pos(X0, Y0, "dir_flush");
    scan(60, "s1234");

    load_and_wait(10000, "clamp10000");
    load_and_wait(16383, "clamp16383");
    load_and_wait(0, "c0");
    scan(40, "s0");
    load_and_wait(42, "c42");
    scan(40, "s42");
    for (int k = 0; k < 6; k++) begin
      v = (k < 3) ? $urandom_range(9999, 0) : $urandom_range(16383, 0);
      load_and_wait(v, "crand");
      scan(30, "srand");
    end

    chain(42, 77, 2, 88, 7, "pend");
    chain(555, 321, 13, 0, -1, "commit_ld");

    @(negedge Clk);
    score_in = 14'd1234;
    score_load = 1'b1;
    @(negedge Clk);
    score_load = 1'b0;
    repeat (6) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    shown = 0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_digits", 32'(digits_out), 32'd0);
    repeat (20) @(negedge Clk);
    check("abort_late_busy", 32'(busy), 32'd0);
    check("abort_late_digits", 32'(digits_out), 32'd0);
    scan(20, "sabort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
